// File: rtl/algo_1r4w_a209_req_stage.sv
// rtl/algo_1r4w_a209_req_stage.sv - request front-end for the 1R4W a209 memory core
// Per-port write FIFOs, one read FIFO with RAW hold-off, and an in-order read tag queue.
module algo_1r4w_a209_req_stage #(
  parameter int NUMWRPT  = 4,
  parameter int WIDTH    = 32,
  parameter int BITADDR  = 13,
  parameter int FIFODEP  = 4,
  parameter int BITFIFO  = 2,
  parameter int TAGWDTH  = 4,
  parameter int MAXOUTRD = 8,
  parameter int BITOUTRD = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUMWRPT-1:0]         wq_vld,
  output logic [NUMWRPT-1:0]         wq_rdy,
  input  logic [NUMWRPT*BITADDR-1:0] wq_adr,
  input  logic [NUMWRPT*WIDTH-1:0]   wq_din,
  input  logic                       rq_vld,
  output logic                       rq_rdy,
  input  logic [BITADDR-1:0]         rq_adr,
  input  logic [TAGWDTH-1:0]         rq_tag,
  input  logic                       mem_ready,
  output logic [NUMWRPT-1:0]         write,
  output logic [NUMWRPT*BITADDR-1:0] wr_adr,
  output logic [NUMWRPT*WIDTH-1:0]   din,
  output logic                       read,
  output logic [BITADDR-1:0]         rd_adr,
  input  logic                       rd_vld,
  input  logic [WIDTH-1:0]           rd_dout,
  input  logic                       rd_serr,
  input  logic                       rd_derr,
  output logic                       rs_vld,
  output logic [WIDTH-1:0]           rs_dout,
  output logic [TAGWDTH-1:0]         rs_tag,
  output logic [1:0]                 rs_err,
  output logic                       tag_ovf
);

  localparam logic [BITFIFO:0]  FIFO_FULL = (BITFIFO+1)'(FIFODEP);
  localparam logic [BITOUTRD:0] TQ_FULL   = (BITOUTRD+1)'(MAXOUTRD);

  logic [BITADDR-1:0] wf_adr_q [NUMWRPT][FIFODEP];
  logic [WIDTH-1:0]   wf_dat_q [NUMWRPT][FIFODEP];
  logic [BITFIFO-1:0] wf_wp_q  [NUMWRPT];
  logic [BITFIFO-1:0] wf_rp_q  [NUMWRPT];
  logic [BITFIFO:0]   wf_cnt_q [NUMWRPT];

  logic [BITADDR-1:0] rf_adr_q [FIFODEP];
  logic [TAGWDTH-1:0] rf_tag_q [FIFODEP];
  logic [BITFIFO-1:0] rf_wp_q, rf_rp_q;
  logic [BITFIFO:0]   rf_cnt_q;

  logic [TAGWDTH-1:0]  tq_mem_q [MAXOUTRD];
  logic [BITOUTRD-1:0] tq_wp_q, tq_rp_q;
  logic [BITOUTRD:0]   tq_cnt_q;

  logic [NUMWRPT-1:0]         write_q;
  logic [NUMWRPT*BITADDR-1:0] wr_adr_q;
  logic [NUMWRPT*WIDTH-1:0]   din_q;
  logic                       read_q;
  logic [BITADDR-1:0]         rd_adr_q;
  logic                       rs_vld_q;
  logic [WIDTH-1:0]           rs_dout_q;
  logic [TAGWDTH-1:0]         rs_tag_q;
  logic [1:0]                 rs_err_q;
  logic                       tag_ovf_q;

  logic [NUMWRPT-1:0] wf_empty, wf_full, wq_push, wr_blk, wr_issue;
  logic [BITADDR-1:0] wf_head_adr [NUMWRPT];
  logic [WIDTH-1:0]   wf_head_dat [NUMWRPT];
  logic               rf_empty, rf_full, rq_push, rd_hit, rd_issue;
  logic [BITADDR-1:0] rf_head_adr;
  logic               tq_empty, tq_full, tq_pop;

  always_comb begin
    for (int i = 0; i < NUMWRPT; i++) begin
      wf_empty[i]    = (wf_cnt_q[i] == '0);
      wf_full[i]     = (wf_cnt_q[i] == FIFO_FULL);
      wq_push[i]     = wq_vld[i] && !wf_full[i];
      wf_head_adr[i] = wf_adr_q[i][wf_rp_q[i]];
      wf_head_dat[i] = wf_dat_q[i][wf_rp_q[i]];
    end
  end

  // A head loses to any lower-index non-empty head with the same address.
  always_comb begin
    wr_blk   = '0;
    wr_issue = '0;
    for (int i = 0; i < NUMWRPT; i++) begin
      for (int j = 0; j < NUMWRPT; j++) begin
        if (j < i && !wf_empty[j] && wf_head_adr[j] == wf_head_adr[i]) wr_blk[i] = 1'b1;
      end
      wr_issue[i] = mem_ready && !wf_empty[i] && !wr_blk[i];
    end
  end

  assign rf_empty    = (rf_cnt_q == '0);
  assign rf_full     = (rf_cnt_q == FIFO_FULL);
  assign rq_push     = rq_vld && !rf_full;
  assign rf_head_adr = rf_adr_q[rf_rp_q];
  assign tq_empty    = (tq_cnt_q == '0);
  assign tq_full     = (tq_cnt_q == TQ_FULL);
  assign tq_pop      = rd_vld && !tq_empty;

  // Read waits while its address sits anywhere in a write FIFO or is being issued now.
  always_comb begin
    rd_hit = 1'b0;
    for (int i = 0; i < NUMWRPT; i++) begin
      for (int k = 0; k < FIFODEP; k++) begin
        if ((BITFIFO+1)'(k) < wf_cnt_q[i] &&
            wf_adr_q[i][wf_rp_q[i] + BITFIFO'(k)] == rf_head_adr) rd_hit = 1'b1;
      end
      if (wr_issue[i] && wf_head_adr[i] == rf_head_adr) rd_hit = 1'b1;
    end
    rd_issue = mem_ready && !rf_empty && !tq_full && !rd_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUMWRPT; i++) begin
        wf_wp_q[i]  <= '0;
        wf_rp_q[i]  <= '0;
        wf_cnt_q[i] <= '0;
      end
      rf_wp_q   <= '0;
      rf_rp_q   <= '0;
      rf_cnt_q  <= '0;
      tq_wp_q   <= '0;
      tq_rp_q   <= '0;
      tq_cnt_q  <= '0;
      write_q   <= '0;
      wr_adr_q  <= '0;
      din_q     <= '0;
      read_q    <= 1'b0;
      rd_adr_q  <= '0;
      rs_vld_q  <= 1'b0;
      rs_dout_q <= '0;
      rs_tag_q  <= '0;
      rs_err_q  <= '0;
      tag_ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUMWRPT; i++) begin
        if (wq_push[i]) begin
          wf_adr_q[i][wf_wp_q[i]] <= wq_adr[i*BITADDR +: BITADDR];
          wf_dat_q[i][wf_wp_q[i]] <= wq_din[i*WIDTH +: WIDTH];
          wf_wp_q[i]              <= wf_wp_q[i] + 1'b1;
        end
        if (wr_issue[i]) begin
          wf_rp_q[i]                     <= wf_rp_q[i] + 1'b1;
          wr_adr_q[i*BITADDR +: BITADDR] <= wf_head_adr[i];
          din_q[i*WIDTH +: WIDTH]        <= wf_head_dat[i];
        end
        case ({wq_push[i], wr_issue[i]})
          2'b10:   wf_cnt_q[i] <= wf_cnt_q[i] + 1'b1;
          2'b01:   wf_cnt_q[i] <= wf_cnt_q[i] - 1'b1;
          default: wf_cnt_q[i] <= wf_cnt_q[i];
        endcase
      end
      write_q <= wr_issue;

      if (rq_push) begin
        rf_adr_q[rf_wp_q] <= rq_adr;
        rf_tag_q[rf_wp_q] <= rq_tag;
        rf_wp_q           <= rf_wp_q + 1'b1;
      end
      if (rd_issue) begin
        rf_rp_q           <= rf_rp_q + 1'b1;
        rd_adr_q          <= rf_head_adr;
        tq_mem_q[tq_wp_q] <= rf_tag_q[rf_rp_q];
        tq_wp_q           <= tq_wp_q + 1'b1;
      end
      case ({rq_push, rd_issue})
        2'b10:   rf_cnt_q <= rf_cnt_q + 1'b1;
        2'b01:   rf_cnt_q <= rf_cnt_q - 1'b1;
        default: rf_cnt_q <= rf_cnt_q;
      endcase
      read_q <= rd_issue;

      if (tq_pop) tq_rp_q <= tq_rp_q + 1'b1;
      case ({rd_issue, tq_pop})
        2'b10:   tq_cnt_q <= tq_cnt_q + 1'b1;
        2'b01:   tq_cnt_q <= tq_cnt_q - 1'b1;
        default: tq_cnt_q <= tq_cnt_q;
      endcase

      rs_vld_q <= rd_vld;
      if (rd_vld) begin
        rs_dout_q <= rd_dout;
        rs_err_q  <= {rd_derr, rd_serr};
        rs_tag_q  <= tq_empty ? '0 : tq_mem_q[tq_rp_q];
        if (tq_empty) tag_ovf_q <= 1'b1;
      end
    end
  end

  assign wq_rdy  = ~wf_full;
  assign rq_rdy  = !rf_full;
  assign write   = write_q;
  assign wr_adr  = wr_adr_q;
  assign din     = din_q;
  assign read    = read_q;
  assign rd_adr  = rd_adr_q;
  assign rs_vld  = rs_vld_q;
  assign rs_dout = rs_dout_q;
  assign rs_tag  = rs_tag_q;
  assign rs_err  = rs_err_q;
  assign tag_ovf = tag_ovf_q;

endmodule

// File: tb/tb_algo_1r4w_a209_req_stage.sv
// tb/tb_algo_1r4w_a209_req_stage.sv - directed bench for algo_1r4w_a209_req_stage
module tb_algo_1r4w_a209_req_stage;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   wq_vld;
  logic [3:0]   wq_rdy;
  logic [51:0]  wq_adr;
  logic [127:0] wq_din;
  logic         rq_vld;
  logic         rq_rdy;
  logic [12:0]  rq_adr;
  logic [3:0]   rq_tag;
  logic         mem_ready;
  logic [3:0]   write;
  logic [51:0]  wr_adr;
  logic [127:0] din;
  logic         read;
  logic [12:0]  rd_adr;
  logic         rd_vld;
  logic [31:0]  rd_dout;
  logic         rd_serr;
  logic         rd_derr;
  logic         rs_vld;
  logic [31:0]  rs_dout;
  logic [3:0]   rs_tag;
  logic [1:0]   rs_err;
  logic         tag_ovf;

  int vec  = 0;
  int errs = 0;

  algo_1r4w_a209_req_stage dut (
    .clk(clk), .rst(rst),
    .wq_vld(wq_vld), .wq_rdy(wq_rdy), .wq_adr(wq_adr), .wq_din(wq_din),
    .rq_vld(rq_vld), .rq_rdy(rq_rdy), .rq_adr(rq_adr), .rq_tag(rq_tag),
    .mem_ready(mem_ready),
    .write(write), .wr_adr(wr_adr), .din(din), .read(read), .rd_adr(rd_adr),
    .rd_vld(rd_vld), .rd_dout(rd_dout), .rd_serr(rd_serr), .rd_derr(rd_derr),
    .rs_vld(rs_vld), .rs_dout(rs_dout), .rs_tag(rs_tag), .rs_err(rs_err),
    .tag_ovf(tag_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    vec++; if (wq_rdy !== 4'hF) begin errs++; $display("FAIL reset_wq_rdy got %h exp f", wq_rdy); end
    vec++; if (rq_rdy !== 1'b1) begin errs++; $display("FAIL reset_rq_rdy got %b exp 1", rq_rdy); end
    vec++; if (write !== 4'h0) begin errs++; $display("FAIL reset_write got %h exp 0", write); end
    vec++; if (read !== 1'b0) begin errs++; $display("FAIL reset_read got %b exp 0", read); end
    vec++; if (tag_ovf !== 1'b0 || rs_vld !== 1'b0) begin errs++; $display("FAIL reset_ovf_rs got %b%b exp 00", tag_ovf, rs_vld); end
  endtask

  task automatic test_four_writes();
    mem_ready = 1'b1;
    wq_vld = 4'hF;
    wq_adr = {13'h40, 13'h30, 13'h20, 13'h10};
    wq_din = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    step();
    wq_vld = 4'h0;
    vec++; if (write !== 4'h0) begin errs++; $display("FAIL wr4_early got %h exp 0", write); end
    step();
    vec++; if (write !== 4'hF) begin errs++; $display("FAIL wr4_write got %h exp f", write); end
    vec++; if (wr_adr !== {13'h40, 13'h30, 13'h20, 13'h10}) begin errs++; $display("FAIL wr4_adr got %h exp %h", wr_adr, {13'h40, 13'h30, 13'h20, 13'h10}); end
    vec++; if (din !== {32'hD3, 32'hD2, 32'hD1, 32'hD0}) begin errs++; $display("FAIL wr4_din got %h", din); end
    step();
    vec++; if (write !== 4'h0) begin errs++; $display("FAIL wr4_after got %h exp 0", write); end
  endtask

  task automatic test_collision();
    wq_vld = 4'b0101;
    wq_adr = {13'h0, 13'h55, 13'h0, 13'h55};
    wq_din = {32'h0, 32'hC2, 32'h0, 32'hC0};
    step();
    wq_vld = 4'h0;
    step();
    vec++; if (write !== 4'b0001) begin errs++; $display("FAIL coll_first got %b exp 0001", write); end
    vec++; if (wr_adr[12:0] !== 13'h55 || din[31:0] !== 32'hC0) begin errs++; $display("FAIL coll_p0 got %h/%h exp 55/c0", wr_adr[12:0], din[31:0]); end
    step();
    vec++; if (write !== 4'b0100) begin errs++; $display("FAIL coll_second got %b exp 0100", write); end
    vec++; if (wr_adr[38:26] !== 13'h55 || din[95:64] !== 32'hC2) begin errs++; $display("FAIL coll_p2 got %h/%h exp 55/c2", wr_adr[38:26], din[95:64]); end
    step();
    vec++; if (write !== 4'h0) begin errs++; $display("FAIL coll_after got %b exp 0000", write); end
  endtask

  task automatic test_raw_order();
    mem_ready = 1'b0;
    wq_vld = 4'b0010;
    wq_adr = {13'h0, 13'h0, 13'h7, 13'h0};
    wq_din = {32'h0, 32'h0, 32'h77, 32'h0};
    step();
    wq_vld = 4'h0;
    rq_vld = 1'b1; rq_adr = 13'h7; rq_tag = 4'd5;
    step();
    rq_vld = 1'b0;
    vec++; if (write !== 4'h0 || read !== 1'b0) begin errs++; $display("FAIL raw_stall got %b/%b exp 0000/0", write, read); end
    mem_ready = 1'b1;
    step();
    vec++; if (write !== 4'b0010 || read !== 1'b0) begin errs++; $display("FAIL raw_wr_first got %b/%b exp 0010/0", write, read); end
    step();
    vec++; if (read !== 1'b1 || rd_adr !== 13'h7 || write !== 4'h0) begin errs++; $display("FAIL raw_rd_next got %b/%h/%b exp 1/7/0000", read, rd_adr, write); end
    rd_vld = 1'b1; rd_dout = 32'hCAFE0007; rd_serr = 1'b1; rd_derr = 1'b0;
    step();
    rd_vld = 1'b0; rd_serr = 1'b0;
    vec++; if (rs_vld !== 1'b1 || rs_tag !== 4'd5) begin errs++; $display("FAIL raw_resp got %b/%0d exp 1/5", rs_vld, rs_tag); end
    vec++; if (rs_dout !== 32'hCAFE0007 || rs_err !== 2'b01) begin errs++; $display("FAIL raw_resp_data got %h/%b exp cafe0007/01", rs_dout, rs_err); end
    step();
    vec++; if (rs_vld !== 1'b0) begin errs++; $display("FAIL raw_resp_drop got %b exp 0", rs_vld); end
  endtask

  task automatic test_tag_limit();
    int n_push = 0;
    int n_rd = 0;
    logic acc;
    mem_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      rq_vld = (n_push < 9);
      rq_adr = 13'h100 + 13'(n_push);
      rq_tag = 4'(n_push);
      acc = rq_vld && rq_rdy;
      step();
      if (acc) n_push++;
      if (read) n_rd++;
    end
    rq_vld = 1'b0;
    vec++; if (n_push !== 9) begin errs++; $display("FAIL tag_pushes got %0d exp 9", n_push); end
    vec++; if (n_rd !== 8) begin errs++; $display("FAIL tag_issued got %0d exp 8", n_rd); end
    vec++; if (read !== 1'b0) begin errs++; $display("FAIL tag_stall got %b exp 0", read); end
    rd_vld = 1'b1; rd_dout = 32'hA0;
    step();
    rd_vld = 1'b0;
    vec++; if (rs_vld !== 1'b1 || rs_tag !== 4'd0 || rs_dout !== 32'hA0) begin errs++; $display("FAIL tag_first got %b/%0d/%h exp 1/0/a0", rs_vld, rs_tag, rs_dout); end
    step();
    vec++; if (read !== 1'b1 || rd_adr !== 13'h108) begin errs++; $display("FAIL tag_ninth got %b/%h exp 1/108", read, rd_adr); end
    for (int i = 1; i <= 8; i++) begin
      rd_vld = 1'b1; rd_dout = 32'hA0 + 32'(i);
      step();
      vec++; if (rs_vld !== 1'b1 || rs_tag !== 4'(i)) begin errs++; $display("FAIL tag_order[%0d] got %b/%0d exp 1/%0d", i, rs_vld, rs_tag, i); end
    end
    rd_vld = 1'b0;
    step();
    vec++; if (rs_vld !== 1'b0 || tag_ovf !== 1'b0) begin errs++; $display("FAIL tag_drain got %b/%b exp 0/0", rs_vld, tag_ovf); end
    rd_vld = 1'b1; rd_dout = 32'hEE;
    step();
    rd_vld = 1'b0;
    vec++; if (rs_vld !== 1'b1 || rs_tag !== 4'd0 || tag_ovf !== 1'b1) begin errs++; $display("FAIL tag_ovf got %b/%0d/%b exp 1/0/1", rs_vld, rs_tag, tag_ovf); end
    step();
    vec++; if (tag_ovf !== 1'b1) begin errs++; $display("FAIL tag_ovf_sticky got %b exp 1", tag_ovf); end
  endtask

  task automatic test_full_and_reset();
    mem_ready = 1'b0;
    wq_adr = {13'h0, 13'h0, 13'h0, 13'h1A};
    wq_din = 128'h0;
    for (int i = 0; i < 5; i++) begin
      wq_vld = 4'b0001;
      vec++; if (wq_rdy[0] !== (i < 4)) begin errs++; $display("FAIL full_rdy[%0d] got %b exp %b", i, wq_rdy[0], (i < 4)); end
      step();
    end
    wq_vld = 4'h0;
    rq_vld = 1'b1; rq_adr = 13'h1A; rq_tag = 4'd3;
    step();
    rq_vld = 1'b0;
    mem_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    vec++; if (wq_rdy !== 4'hF || rq_rdy !== 1'b1) begin errs++; $display("FAIL rst_rdy got %h/%b exp f/1", wq_rdy, rq_rdy); end
    vec++; if (tag_ovf !== 1'b0 || write !== 4'h0 || read !== 1'b0) begin errs++; $display("FAIL rst_out got %b/%h/%b exp 0/0/0", tag_ovf, write, read); end
    for (int i = 0; i < 3; i++) begin
      step();
      vec++; if (write !== 4'h0 || read !== 1'b0) begin errs++; $display("FAIL rst_stale[%0d] got %h/%b exp 0/0", i, write, read); end
    end
  endtask

  initial begin
    rst = 1'b1; wq_vld = '0; wq_adr = '0; wq_din = '0;
    rq_vld = 1'b0; rq_adr = '0; rq_tag = '0; mem_ready = 1'b0;
    rd_vld = 1'b0; rd_dout = '0; rd_serr = 1'b0; rd_derr = 1'b0;
    test_reset();
    test_four_writes();
    test_collision();
    test_raw_order();
    test_tag_limit();
    test_full_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
